// File: rtl/instruction_fetch.sv
// Instruction fetch stage: requests words from instruction memory and hands them to decode.
// Optional halt-opcode support is enabled by defining the macro IFETCH_HALT_EN.
module instruction_fetch (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        branch_taken,
  input  logic [7:0]  branch_target,
  output logic [7:0]  imem_addr,
  output logic        imem_rd,
  input  logic [15:0] imem_data,
  input  logic        imem_ack,
  output logic [15:0] instr,
  output logic        en,
  output logic [7:0]  pc,
  output logic        halted
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    HOLD = 2'd2
`ifdef IFETCH_HALT_EN
    ,
    HALT = 2'd3
`endif
  } state_t;

  state_t      r_state;
  logic [7:0]  r_pc;
  logic [15:0] r_instr;
  logic        r_en;

  state_t      w_stateNext;
  logic [7:0]  w_pcNext;
  logic [15:0] w_instrNext;
  logic        w_enNext;
  logic        w_branchOk;
  logic        w_ackHalts;
  logic        w_heldHalts;

`ifdef IFETCH_HALT_EN
  // A frozen fetch ignores redirects; only reset can wake it.
  assign w_branchOk  = branch_taken && (r_state != HALT);
  assign w_ackHalts  = (imem_data[15:11] == 5'b11110);
  assign w_heldHalts = (r_instr[15:11] == 5'b11110);
`else
  assign w_branchOk  = branch_taken;
  assign w_ackHalts  = 1'b0;
  assign w_heldHalts = 1'b0;
`endif

  always_comb begin
    w_stateNext = r_state;
    w_pcNext    = r_pc;
    w_instrNext = r_instr;
    w_enNext    = 1'b0;

    case (r_state)
      IDLE: begin
        if (!stall) w_stateNext = REQ;
      end
      REQ: begin
        if (imem_ack) begin
          w_instrNext = imem_data;
          w_pcNext    = r_pc + 8'd1;
          if (stall) begin
            w_stateNext = HOLD;
          end else begin
            w_enNext = 1'b1;
`ifdef IFETCH_HALT_EN
            if (w_ackHalts) w_stateNext = HALT;
`endif
          end
        end
      end
      HOLD: begin
        if (!stall) begin
          w_enNext    = 1'b1;
          w_stateNext = IDLE;
`ifdef IFETCH_HALT_EN
          if (w_heldHalts) w_stateNext = HALT;
`endif
        end
      end
      default: begin
        w_stateNext = r_state;
      end
    endcase

    // A redirect overrides everything: drop any word arriving now and restart from idle.
    if (w_branchOk) begin
      w_stateNext = IDLE;
      w_pcNext    = branch_target;
      w_instrNext = r_instr;
      w_enNext    = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_pc    <= 8'h00;
      r_instr <= 16'h0000;
      r_en    <= 1'b0;
    end else begin
      r_state <= w_stateNext;
      r_pc    <= w_pcNext;
      r_instr <= w_instrNext;
      r_en    <= w_enNext;
    end
  end

  assign imem_rd   = (r_state == REQ);
  assign imem_addr = r_pc;
  assign pc        = r_pc;
  assign instr     = r_instr;
  assign en        = r_en;

`ifdef IFETCH_HALT_EN
  assign halted = (r_state == HALT);
`else
  assign halted = 1'b0;
`endif

endmodule

// File: tb/tb_instruction_fetch.sv
// Bench for instruction_fetch: directed vector table, hand-written halt sequence,
// then randomized traffic against an event-level reference model.
module tb_instruction_fetch;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall;
  logic        branch_taken;
  logic [7:0]  branch_target;
  logic [7:0]  imem_addr;
  logic        imem_rd;
  logic [15:0] imem_data;
  logic        imem_ack;
  logic [15:0] instr;
  logic        en;
  logic [7:0]  pc;
  logic        halted;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  instruction_fetch dut (
    .clk          (clk),
    .rst          (rst),
    .stall        (stall),
    .branch_taken (branch_taken),
    .branch_target(branch_target),
    .imem_addr    (imem_addr),
    .imem_rd      (imem_rd),
    .imem_data    (imem_data),
    .imem_ack     (imem_ack),
    .instr        (instr),
    .en           (en),
    .pc           (pc),
    .halted       (halted)
  );

  typedef struct {
    logic        rst;
    logic        stall;
    logic        br;
    logic [7:0]  tgt;
    logic        ack;
    logic [15:0] data;
    logic        expEn;
    logic [15:0] expInstr;
    logic [7:0]  expPc;
    logic        expRd;
    logic [7:0]  expAddr;
  } vec_t;

  vec_t vecs[$];

  // Reference model: outstanding request, word held behind a stall, halted
  bit          mReq;
  bit          mHeld;
  bit          mHalted;
  bit          mEn;
  logic [7:0]  mPc;
  logic [15:0] mInstr;

  function automatic vec_t mkVec(logic r, logic s, logic b, logic [7:0] t, logic a,
                                 logic [15:0] d, logic e, logic [15:0] ins, logic [7:0] p,
                                 logic rd, logic [7:0] ad);
    vec_t v;
    v.rst = r; v.stall = s; v.br = b; v.tgt = t; v.ack = a; v.data = d;
    v.expEn = e; v.expInstr = ins; v.expPc = p; v.expRd = rd; v.expAddr = ad;
    return v;
  endfunction

  function automatic bit isHaltWord(logic [15:0] w);
`ifdef IFETCH_HALT_EN
    return (w[15:11] == 5'b11110);
`else
    return 1'b0;
`endif
  endfunction

  task automatic checkOutput(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input logic r, input logic s, input logic b, input logic [7:0] t,
                               input logic a, input logic [15:0] d);
    rst           = r;
    stall         = s;
    branch_taken  = b;
    branch_target = t;
    imem_ack      = a;
    imem_data     = d;
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic modelStep(input logic r, input logic s, input logic b, input logic [7:0] t,
                           input logic a, input logic [15:0] d);
    if (r) begin
      mReq = 0; mHeld = 0; mHalted = 0; mEn = 0; mPc = 8'h00; mInstr = 16'h0000;
    end else begin
      mEn = 0;
      if (mHalted) begin
        mEn = 0;
      end else if (b) begin
        mPc = t; mReq = 0; mHeld = 0;
      end else if (mHeld) begin
        if (!s) begin
          mEn = 1; mHeld = 0; mHalted = isHaltWord(mInstr);
        end
      end else if (mReq) begin
        if (a) begin
          mInstr = d;
          mPc    = mPc + 8'd1;
          if (s) begin
            mHeld = 1; mReq = 0;
          end else begin
            mEn = 1;
            if (isHaltWord(d)) begin
              mHalted = 1; mReq = 0;
            end
          end
        end
      end else if (!s) begin
        mReq = 1;
      end
    end
  endtask

  initial begin
    applyStimulus(1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 16'h0000);

    // rst stall br tgt ack data | en instr pc rd addr
    vecs.push_back(mkVec(1,0,0,8'h00,0,16'h0000, 0,16'h0000,8'h00,0,8'h00));
    vecs.push_back(mkVec(0,0,0,8'h00,0,16'h0000, 0,16'h0000,8'h00,1,8'h00));
    vecs.push_back(mkVec(0,0,0,8'h00,0,16'h0000, 0,16'h0000,8'h00,1,8'h00));
    vecs.push_back(mkVec(0,0,0,8'h00,1,16'h1234, 1,16'h1234,8'h01,1,8'h01));
    vecs.push_back(mkVec(0,0,0,8'h00,0,16'h0000, 0,16'h1234,8'h01,1,8'h01));
    vecs.push_back(mkVec(0,1,0,8'h00,0,16'h0000, 0,16'h1234,8'h01,1,8'h01));
    vecs.push_back(mkVec(0,1,0,8'h00,1,16'hA5A5, 0,16'hA5A5,8'h02,0,8'h02));
    vecs.push_back(mkVec(0,1,0,8'h00,0,16'h0000, 0,16'hA5A5,8'h02,0,8'h02));
    vecs.push_back(mkVec(0,1,0,8'h00,0,16'h0000, 0,16'hA5A5,8'h02,0,8'h02));
    vecs.push_back(mkVec(0,0,0,8'h00,0,16'h0000, 1,16'hA5A5,8'h02,0,8'h02));
    vecs.push_back(mkVec(0,0,0,8'h00,0,16'h0000, 0,16'hA5A5,8'h02,1,8'h02));
    vecs.push_back(mkVec(0,0,1,8'h40,1,16'hBEEF, 0,16'hA5A5,8'h40,0,8'h40));
    vecs.push_back(mkVec(0,0,0,8'h00,0,16'h0000, 0,16'hA5A5,8'h40,1,8'h40));
    vecs.push_back(mkVec(0,0,1,8'h10,0,16'h0000, 0,16'hA5A5,8'h10,0,8'h10));
    vecs.push_back(mkVec(0,1,0,8'h00,1,16'h7777, 0,16'hA5A5,8'h10,0,8'h10));
    vecs.push_back(mkVec(0,0,0,8'h00,0,16'h0000, 0,16'hA5A5,8'h10,1,8'h10));
    vecs.push_back(mkVec(1,0,0,8'h00,0,16'h0000, 0,16'h0000,8'h00,0,8'h00));
    vecs.push_back(mkVec(0,1,0,8'h00,1,16'h5555, 0,16'h0000,8'h00,0,8'h00));
    vecs.push_back(mkVec(0,0,0,8'h00,0,16'h0000, 0,16'h0000,8'h00,1,8'h00));
    vecs.push_back(mkVec(1,1,1,8'h77,1,16'h9999, 0,16'h0000,8'h00,0,8'h00));
    vecs.push_back(mkVec(0,0,0,8'h00,0,16'h0000, 0,16'h0000,8'h00,1,8'h00));
    vecs.push_back(mkVec(0,1,0,8'h00,1,16'h1111, 0,16'h1111,8'h01,0,8'h01));
    vecs.push_back(mkVec(0,1,1,8'h20,0,16'h0000, 0,16'h1111,8'h20,0,8'h20));
    vecs.push_back(mkVec(0,0,0,8'h00,0,16'h0000, 0,16'h1111,8'h20,1,8'h20));
    vecs.push_back(mkVec(0,0,1,8'hFF,0,16'h0000, 0,16'h1111,8'hFF,0,8'hFF));
    vecs.push_back(mkVec(0,0,0,8'h00,0,16'h0000, 0,16'h1111,8'hFF,1,8'hFF));
    vecs.push_back(mkVec(0,0,0,8'h00,1,16'h0ABC, 1,16'h0ABC,8'h00,1,8'h00));
    vecs.push_back(mkVec(0,0,0,8'h00,0,16'h0000, 0,16'h0ABC,8'h00,1,8'h00));

    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i].rst, vecs[i].stall, vecs[i].br, vecs[i].tgt, vecs[i].ack, vecs[i].data);
      tick();
      checkOutput($sformatf("vec%0d_en", i),     {15'd0, en},      {15'd0, vecs[i].expEn});
      checkOutput($sformatf("vec%0d_instr", i),  instr,            vecs[i].expInstr);
      checkOutput($sformatf("vec%0d_pc", i),     {8'd0, pc},       {8'd0, vecs[i].expPc});
      checkOutput($sformatf("vec%0d_rd", i),     {15'd0, imem_rd}, {15'd0, vecs[i].expRd});
      checkOutput($sformatf("vec%0d_addr", i),   {8'd0, imem_addr},{8'd0, vecs[i].expAddr});
      checkOutput($sformatf("vec%0d_halted", i), {15'd0, halted},  16'd0);
    end

    // Halt-opcode sequence, starting from an outstanding request at pc 0x00
    applyStimulus(1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 16'hF000);
    tick();
    checkOutput("halt_en",    {15'd0, en}, 16'd1);
    checkOutput("halt_instr", instr,       16'hF000);
    checkOutput("halt_pc",    {8'd0, pc},  16'h0001);
`ifdef IFETCH_HALT_EN
    checkOutput("halt_flag",  {15'd0, halted},  16'd1);
    checkOutput("halt_rd",    {15'd0, imem_rd}, 16'd0);
`else
    checkOutput("halt_flag",  {15'd0, halted},  16'd0);
    checkOutput("halt_rd",    {15'd0, imem_rd}, 16'd1);
    checkOutput("halt_addr",  {8'd0, imem_addr}, 16'h0001);
`endif
    applyStimulus(1'b0, 1'b0, 1'b1, 8'h30, 1'b0, 16'h0000);
    tick();
    checkOutput("halt_br_en", {15'd0, en},      16'd0);
    checkOutput("halt_br_rd", {15'd0, imem_rd}, 16'd0);
`ifdef IFETCH_HALT_EN
    checkOutput("halt_br_pc",     {8'd0, pc},     16'h0001);
    checkOutput("halt_br_halted", {15'd0, halted}, 16'd1);
`else
    checkOutput("halt_br_pc",     {8'd0, pc},     16'h0030);
`endif
    applyStimulus(1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 16'h2222);
    tick();
`ifdef IFETCH_HALT_EN
    checkOutput("halt_stay_rd",  {15'd0, imem_rd}, 16'd0);
    checkOutput("halt_stay_pc",  {8'd0, pc},       16'h0001);
    checkOutput("halt_stay_en",  {15'd0, en},      16'd0);
`else
    checkOutput("run_rd",   {15'd0, imem_rd}, 16'd1);
    checkOutput("run_addr", {8'd0, imem_addr}, 16'h0030);
`endif

    // Randomized traffic against the reference model
    for (int i = 0; i < 3000; i++) begin
      logic        r, s, b, a;
      logic [7:0]  t;
      logic [15:0] d;
      r = (i == 0) || ($urandom_range(0, 63) == 0);
      s = ($urandom_range(0, 3) == 0);
      b = ($urandom_range(0, 15) == 0);
      t = 8'($urandom);
      a = mReq ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 9) == 0);
      d = 16'($urandom);
      if ($urandom_range(0, 7) == 0) d[15:11] = 5'b11110;
      applyStimulus(r, s, b, t, a, d);
      modelStep(r, s, b, t, a, d);
      tick();
      checkOutput("rnd_en",     {15'd0, en},        {15'd0, mEn});
      checkOutput("rnd_instr",  instr,              mInstr);
      checkOutput("rnd_pc",     {8'd0, pc},         {8'd0, mPc});
      checkOutput("rnd_rd",     {15'd0, imem_rd},   {15'd0, mReq});
      checkOutput("rnd_addr",   {8'd0, imem_addr},  {8'd0, mPc});
      checkOutput("rnd_halted", {15'd0, halted},    {15'd0, mHalted});
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
